bcd_time_counter: RTL and testbench



---
 rtl/clock_pkg.sv | 46 ++++
 rtl/bcd_pair_counter.sv | 59 +++++
 rtl/bcd_time_counter.sv | 122 ++++++++++++
 tb/tb_bcd_time_counter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and wrap constants for the BCD time-of-day counter.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_MAX_TENS  = 4'd5;
    localparam bcd_t SEC_MAX_ONES  = 4'd9;
    localparam bcd_t HR24_MAX_TENS = 4'd2;
    localparam bcd_t HR24_MAX_ONES = 4'd3;

    // 12-hour dial: 12 is the top of the sequence, 01 follows it, 11 -> 12 flips AM/PM.
    localparam bcd_t HR12_MAX_TENS = 4'd1;
    localparam bcd_t HR12_MAX_ONES = 4'd2;
    localparam bcd_t HR12_MIN_TENS = 4'd0;
    localparam bcd_t HR12_MIN_ONES = 4'd1;
    localparam bcd_t HR12_PM_TENS  = 4'd1;
    localparam bcd_t HR12_PM_ONES  = 4'd1;

    typedef struct packed {
        logic pm;
        bcd_t tens;
        bcd_t ones;
    } hr12_t;

    localparam hr12_t HR12_RESET = {1'b0, 4'd1, 4'd2};

    function automatic hr12_t hr12_next(input hr12_t cur);
        hr12_t nxt;
        nxt = cur;
        if ((cur.tens == HR12_MAX_TENS) && (cur.ones == HR12_MAX_ONES)) begin
            nxt.tens = HR12_MIN_TENS;
            nxt.ones = HR12_MIN_ONES;
        end else if ((cur.tens == HR12_PM_TENS) && (cur.ones == HR12_PM_ONES)) begin
            nxt.tens = HR12_MAX_TENS;
            nxt.ones = HR12_MAX_ONES;
            nxt.pm   = ~cur.pm;
        end else if (cur.ones == SEC_MAX_ONES) begin
            nxt.tens = cur.tens + 4'd1;
            nxt.ones = 4'd0;
        end else begin
            nxt.ones = cur.ones + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX_TENS:MAX_ONES; wrap_o flags
// the enabled cycle in which that wrap happens.
module bcd_pair_counter
    import clock_pkg::*;
#(
    parameter bcd_t MAX_TENS = SEC_MAX_TENS,
    parameter bcd_t MAX_ONES = SEC_MAX_ONES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output bcd_t tens_o,
    output bcd_t ones_o,
    output logic wrap_o
);

    bcd_t tens_r, ones_r;
    bcd_t tens_next_s, ones_next_s;
    logic at_max_s;

    assign at_max_s = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
    assign wrap_o   = en_i & at_max_s;
    assign tens_o   = tens_r;
    assign ones_o   = ones_r;

    // Next BCD value: wrap at the pair maximum, otherwise ripple 9 -> 0 into tens.
    always_comb begin
        tens_next_s = tens_r;
        ones_next_s = ones_r;
        if (at_max_s) begin
            tens_next_s = 4'd0;
            ones_next_s = 4'd0;
        end else if (ones_r == 4'd9) begin
            tens_next_s = tens_r + 4'd1;
            ones_next_s = 4'd0;
        end else begin
            ones_next_s = ones_r + 4'd1;
        end
    end

    // Digit registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (clr_i) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (en_i) begin
            tens_r <= tens_next_s;
            ones_r <= ones_next_s;
        end else begin
            tens_r <= tens_r;
            ones_r <= ones_r;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// 1 Hz time base and HH:MM:SS BCD counter with push-button set mode.
// Define CLOCK_12H_EN for a 12-hour dial with AM/PM indicator; 24-hour otherwise.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       run_i,
    input  logic       set_i,
    input  logic       inc_min_i,
    input  logic       inc_hr_i,
    output logic [3:0] sec_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] min_ones_o,
    output logic [3:0] min_tens_o,
    output logic [3:0] hr_ones_o,
    output logic [3:0] hr_tens_o,
    output logic       tick_o,
    output logic       pm_o
);

    localparam int             PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_r;
    logic          tick_r;
    logic          min_prev_r, hr_prev_r;
    logic          running_s, tick_s;
    logic          min_rise_s, hr_rise_s;
    logic          sec_wrap_s, min_wrap_s;
    logic          min_en_s, hr_en_s;

    assign running_s  = run_i & ~set_i;
    assign tick_s     = running_s && (presc_r == PRESC_MAX);
    assign min_rise_s = set_i & inc_min_i & ~min_prev_r;
    assign hr_rise_s  = set_i & inc_hr_i & ~hr_prev_r;
    assign min_en_s   = sec_wrap_s | min_rise_s;
    // Minute wrap only carries into hours while counting; in set mode fields are independent.
    assign hr_en_s    = (min_wrap_s & ~set_i) | hr_rise_s;
    assign tick_o     = tick_r;

    // Prescaler, registered tick and button edge trackers (trackers run even outside set mode).
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            presc_r    <= '0;
            tick_r     <= 1'b0;
            min_prev_r <= 1'b0;
            hr_prev_r  <= 1'b0;
        end else begin
            min_prev_r <= inc_min_i;
            hr_prev_r  <= inc_hr_i;
            tick_r     <= tick_s;
            if (!running_s) begin
                presc_r <= '0;
            end else if (tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + 1'b1;
            end
        end
    end

    bcd_pair_counter #(.MAX_TENS(SEC_MAX_TENS), .MAX_ONES(SEC_MAX_ONES)) u_sec (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (set_i),
        .en_i    (tick_s),
        .tens_o  (sec_tens_o),
        .ones_o  (sec_ones_o),
        .wrap_o  (sec_wrap_s)
    );

    bcd_pair_counter #(.MAX_TENS(SEC_MAX_TENS), .MAX_ONES(SEC_MAX_ONES)) u_min (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (1'b0),
        .en_i    (min_en_s),
        .tens_o  (min_tens_o),
        .ones_o  (min_ones_o),
        .wrap_o  (min_wrap_s)
    );

`ifdef CLOCK_12H_EN
    hr12_t hr_r, hr_next_s;

    always_comb begin
        hr_next_s = hr12_next(hr_r);
    end

    // 12-hour register including the AM/PM flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hr_r <= HR12_RESET;
        end else if (hr_en_s) begin
            hr_r <= hr_next_s;
        end else begin
            hr_r <= hr_r;
        end
    end

    assign hr_tens_o = hr_r.tens;
    assign hr_ones_o = hr_r.ones;
    assign pm_o      = hr_r.pm;
`else
    logic hr_wrap_unused_s;

    bcd_pair_counter #(.MAX_TENS(HR24_MAX_TENS), .MAX_ONES(HR24_MAX_ONES)) u_hr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (1'b0),
        .en_i    (hr_en_s),
        .tens_o  (hr_tens_o),
        .ones_o  (hr_ones_o),
        .wrap_o  (hr_wrap_unused_s)
    );

    assign pm_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter with a 4-cycle time base.
module tb_bcd_time_counter;

    localparam int CLK_HZ = 4;
`ifdef CLOCK_12H_EN
    localparam logic [23:0] RST_TIME = 24'h120000;
`else
    localparam logic [23:0] RST_TIME = 24'h000000;
`endif

    logic       clk = 1'b0;
    logic       rst_n_i, run_i, set_i, inc_min_i, inc_hr_i;
    logic [3:0] sec_ones_o, sec_tens_o, min_ones_o, min_tens_o, hr_ones_o, hr_tens_o;
    logic       tick_o, pm_o;
    logic [23:0] time_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign time_s = {hr_tens_o, hr_ones_o, min_tens_o, min_ones_o, sec_tens_o, sec_ones_o};

    bcd_time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .run_i      (run_i),
        .set_i      (set_i),
        .inc_min_i  (inc_min_i),
        .inc_hr_i   (inc_hr_i),
        .sec_ones_o (sec_ones_o),
        .sec_tens_o (sec_tens_o),
        .min_ones_o (min_ones_o),
        .min_tens_o (min_tens_o),
        .hr_ones_o  (hr_ones_o),
        .hr_tens_o  (hr_tens_o),
        .tick_o     (tick_o),
        .pm_o       (pm_o)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; run_i = 1'b0; set_i = 1'b0; inc_min_i = 1'b0; inc_hr_i = 1'b0;
        cyc(2);
        rst_n_i = 1'b1;
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min_i = 1'b1; cyc(1);
            inc_min_i = 1'b0; cyc(1);
        end
    endtask

    task automatic press_hr(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hr_i = 1'b1; cyc(1);
            inc_hr_i = 1'b0; cyc(1);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; run_i = 1'b0; set_i = 1'b0; inc_min_i = 1'b0; inc_hr_i = 1'b0;
        cyc(2);
        checks++; if (time_s !== RST_TIME) begin errors++; $display("FAIL reset_time: got %h expected %h", time_s, RST_TIME); end
        checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick_o); end
        checks++; if (pm_o !== 1'b0) begin errors++; $display("FAIL reset_pm: got %b expected 0", pm_o); end
        rst_n_i = 1'b1;
    endtask

    task automatic test_count();
        logic exp_tick;
        run_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cyc(1);
            exp_tick = ((c % 4) == 0) ? 1'b1 : 1'b0;
            checks++; if (tick_o !== exp_tick) begin errors++; $display("FAIL count_tick c=%0d: got %b expected %b", c, tick_o, exp_tick); end
        end
        checks++; if (time_s !== (RST_TIME + 24'h000010)) begin errors++; $display("FAIL count_10s: got %h expected %h", time_s, RST_TIME + 24'h000010); end
    endtask

    task automatic test_freeze();
        logic exp_tick;
        cyc(2);
        run_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            cyc(1);
            checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL freeze_tick c=%0d: got %b expected 0", c, tick_o); end
            checks++; if (time_s !== (RST_TIME + 24'h000010)) begin errors++; $display("FAIL freeze_time c=%0d: got %h expected %h", c, time_s, RST_TIME + 24'h000010); end
        end
        run_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            exp_tick = (c == 4) ? 1'b1 : 1'b0;
            checks++; if (tick_o !== exp_tick) begin errors++; $display("FAIL resume_tick c=%0d: got %b expected %b", c, tick_o, exp_tick); end
        end
        checks++; if (time_s !== (RST_TIME + 24'h000011)) begin errors++; $display("FAIL resume_time: got %h expected %h", time_s, RST_TIME + 24'h000011); end
        run_i = 1'b0;
    endtask

    task automatic test_set();
        do_reset();
        set_i = 1'b1; cyc(1);
        press_hr(10);
        press_min(37);
        set_i = 1'b0; run_i = 1'b1;
        cyc(100);
        checks++; if (time_s !== 24'h103725) begin errors++; $display("FAIL set_preload: got %h expected 103725", time_s); end
        set_i = 1'b1; cyc(1);
        checks++; if (time_s !== 24'h103700) begin errors++; $display("FAIL set_sec_clear: got %h expected 103700", time_s); end
        press_min(25);
        checks++; if (time_s !== 24'h100200) begin errors++; $display("FAIL set_min_wrap: got %h expected 100200", time_s); end
        inc_min_i = 1'b1; inc_hr_i = 1'b1; cyc(1);
        inc_min_i = 1'b0; inc_hr_i = 1'b0; cyc(1);
        checks++; if (time_s !== 24'h110300) begin errors++; $display("FAIL set_both: got %h expected 110300", time_s); end
        inc_hr_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc(1);
            checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL set_tick c=%0d: got %b expected 0", c, tick_o); end
        end
        inc_hr_i = 1'b0; cyc(1);
        checks++; if (time_s !== 24'h120300) begin errors++; $display("FAIL set_held_hr: got %h expected 120300", time_s); end
        set_i = 1'b0; run_i = 1'b0;
        press_min(3);
        checks++; if (time_s !== 24'h120300) begin errors++; $display("FAIL edge_ignored: got %h expected 120300", time_s); end
        inc_min_i = 1'b1; cyc(1);
        set_i = 1'b1; cyc(2);
        checks++; if (time_s !== 24'h120300) begin errors++; $display("FAIL no_stale_edge: got %h expected 120300", time_s); end
        inc_min_i = 1'b0; set_i = 1'b0; cyc(1);
    endtask

`ifndef CLOCK_12H_EN
    task automatic test_rollover();
        do_reset();
        set_i = 1'b1; cyc(1);
        press_hr(23);
        press_min(59);
        set_i = 1'b0; run_i = 1'b1;
        cyc(232);
        checks++; if (time_s !== 24'h235958) begin errors++; $display("FAIL roll_pre: got %h expected 235958", time_s); end
        cyc(4);
        checks++; if (time_s !== 24'h235959) begin errors++; $display("FAIL roll_59: got %h expected 235959", time_s); end
        cyc(3);
        checks++; if (time_s !== 24'h235959 || tick_o !== 1'b0) begin errors++; $display("FAIL roll_hold: got %h tick %b expected 235959 tick 0", time_s, tick_o); end
        cyc(1);
        checks++; if (time_s !== 24'h000000) begin errors++; $display("FAIL roll_wrap: got %h expected 000000", time_s); end
        checks++; if (tick_o !== 1'b1) begin errors++; $display("FAIL roll_tick: got %b expected 1", tick_o); end
        run_i = 1'b0;
    endtask
`else
    task automatic test_12h();
        do_reset();
        set_i = 1'b1; cyc(1);
        press_hr(11);
        press_min(59);
        set_i = 1'b0; run_i = 1'b1;
        cyc(236);
        checks++; if (time_s !== 24'h115959 || pm_o !== 1'b0) begin errors++; $display("FAIL h12_1159: got %h pm %b expected 115959 pm 0", time_s, pm_o); end
        cyc(4);
        checks++; if (time_s !== 24'h120000 || pm_o !== 1'b1) begin errors++; $display("FAIL h12_noon: got %h pm %b expected 120000 pm 1", time_s, pm_o); end
        set_i = 1'b1; cyc(1);
        press_min(59);
        set_i = 1'b0;
        cyc(236);
        checks++; if (time_s !== 24'h125959 || pm_o !== 1'b1) begin errors++; $display("FAIL h12_1259: got %h pm %b expected 125959 pm 1", time_s, pm_o); end
        cyc(4);
        checks++; if (time_s !== 24'h010000 || pm_o !== 1'b1) begin errors++; $display("FAIL h12_one: got %h pm %b expected 010000 pm 1", time_s, pm_o); end
        set_i = 1'b1; cyc(1);
        press_hr(10);
        checks++; if (time_s !== 24'h110000 || pm_o !== 1'b1) begin errors++; $display("FAIL h12_11pm: got %h pm %b expected 110000 pm 1", time_s, pm_o); end
        press_hr(1);
        checks++; if (time_s !== 24'h120000 || pm_o !== 1'b0) begin errors++; $display("FAIL h12_midnight: got %h pm %b expected 120000 pm 0", time_s, pm_o); end
        set_i = 1'b0; run_i = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_set();
        do_reset();
        set_i = 1'b1; cyc(1);
        press_min(5);
        press_hr(3);
        inc_min_i = 1'b1; inc_hr_i = 1'b1; rst_n_i = 1'b0;
        cyc(1);
        checks++; if (time_s !== RST_TIME) begin errors++; $display("FAIL midset_time: got %h expected %h", time_s, RST_TIME); end
        checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL midset_tick: got %b expected 0", tick_o); end
        checks++; if (pm_o !== 1'b0) begin errors++; $display("FAIL midset_pm: got %b expected 0", pm_o); end
        rst_n_i = 1'b1; inc_min_i = 1'b0; inc_hr_i = 1'b0; set_i = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst_n_i = 1'b0; run_i = 1'b0; set_i = 1'b0; inc_min_i = 1'b0; inc_hr_i = 1'b0;
        test_reset();
        test_count();
        test_freeze();
        test_set();
`ifndef CLOCK_12H_EN
        test_rollover();
`else
        test_12h();
`endif
        test_reset_mid_set();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
